// File: rtl/escalonador_somador.sv
// escalonador_somador
// Round-robin scheduler and sequencer for a shared accumulating adder.
// One requester at a time owns the datapath. Its operand pairs pass through
// a two-stage pipeline: the pair sum is registered, then added into the
// accumulator. The total comes back with a sticky carry-out flag.
//
// Ports
//   clock, reset_n   rising-edge clock, async active-low reset
//   req_valid        per-requester job pending (level)
//   req_len          per-requester job length, requester i at [i*LEN_W +: LEN_W]
//   op_a, op_b       operand pair from the granted requester
//   op_valid         operand pair valid
//   op_ready         pair is accepted this cycle when op_valid is also high
//   grant            one-hot owner, zero while idle
//   result           accumulated total (holds until the next job clears it)
//   result_ovf       OR of every carry-out in the job
//   result_valid     one-cycle pulse marking result/result_ovf/grant
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | arbitrate among req_valid, starting after last_id
// CLEAR  | zero accumulator/overflow, load pair count
// ACCUM  | accept operand pairs until the count is exhausted
// DRAIN  | stage 2 absorbs the final registered pair sum
// DONE   | present result for one cycle, remember the owner

module escalonador_somador #(
    parameter int WIDTH = 44,
    parameter int N_REQ = 4,
    parameter int LEN_W = 4
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*LEN_W-1:0] req_len,
    input  logic [WIDTH-1:0]       op_a,
    input  logic [WIDTH-1:0]       op_b,
    input  logic                   op_valid,
    output logic                   op_ready,
    output logic [N_REQ-1:0]       grant,
    output logic [WIDTH-1:0]       result,
    output logic                   result_ovf,
    output logic                   result_valid
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ACCUM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [IDX_W-1:0] last_id, cur_id;
    logic [IDX_W-1:0] id_hi, id_any, win_id;
    logic             found_hi;
    logic [LEN_W-1:0] win_len, cur_len, count;
    logic [WIDTH-1:0] acc, s1;
    logic             s1_valid, ovf;
    logic             accept;
    logic [WIDTH:0]   pair_sum, acc_sum;

    // Round-robin pick: the lowest requester above last_id wins; if none is
    // above it, wrap around to the lowest requester overall.
    always_comb begin
        id_hi    = '0;
        id_any   = '0;
        found_hi = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                id_any = IDX_W'(i);
                if (i > int'(last_id)) begin
                    id_hi    = IDX_W'(i);
                    found_hi = 1'b1;
                end
            end
        end
        win_id = found_hi ? id_hi : id_any;
    end

    always_comb begin
        win_len = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (IDX_W'(i) == win_id) begin
                win_len = req_len[i*LEN_W +: LEN_W];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        op_ready     = 1'b0;
        result_valid = 1'b0;
        case (state)
            S_IDLE: begin
                if (|req_valid) begin
                    state_nxt = S_CLEAR;
                end
            end
            S_CLEAR: begin
                state_nxt = (cur_len == '0) ? S_DRAIN : S_ACCUM;
            end
            S_ACCUM: begin
                op_ready = 1'b1;
                if (op_valid && count == LEN_W'(1)) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                state_nxt = S_DONE;
            end
            S_DONE: begin
                result_valid = 1'b1;
                state_nxt    = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign accept   = op_valid & op_ready;
    assign pair_sum = {1'b0, op_a} + {1'b0, op_b};
    assign acc_sum  = {1'b0, acc} + {1'b0, s1};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_id  <= IDX_W'(N_REQ - 1);
            cur_id   <= '0;
            cur_len  <= '0;
            count    <= '0;
            acc      <= '0;
            s1       <= '0;
            s1_valid <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            if (state == S_IDLE && |req_valid) begin
                cur_id  <= win_id;
                cur_len <= win_len;
            end

            // Stage 1 (pair sum) and stage 2 (accumulate) run concurrently,
            // so both carries can land in the same cycle.
            s1_valid <= accept;
            if (accept) begin
                s1    <= pair_sum[WIDTH-1:0];
                count <= count - LEN_W'(1);
            end
            if (s1_valid) begin
                acc <= acc_sum[WIDTH-1:0];
            end
            ovf <= ovf | (accept & pair_sum[WIDTH]) | (s1_valid & acc_sum[WIDTH]);

            if (state == S_CLEAR) begin
                acc      <= '0;
                s1_valid <= 1'b0;
                ovf      <= 1'b0;
                count    <= cur_len;
            end

            if (state == S_DONE) begin
                last_id <= cur_id;
            end
        end
    end

    assign grant      = (state == S_IDLE) ? '0 : (N_REQ'(1) << cur_id);
    assign result     = acc;
    assign result_ovf = ovf;

endmodule

// File: tb/tb_escalonador_somador.sv
// Testbench for escalonador_somador: directed scenarios plus randomized jobs,
// checked against a job-level reference model (round-robin pick over the
// request mask, modular sum of the pairs with carry tracking, and expected
// latency from the accept/stall count).

module tb_escalonador_somador;

    localparam int W  = 44;
    localparam int N  = 4;
    localparam int LW = 4;

    logic            clock = 1'b0;
    logic            reset_n;
    logic [N-1:0]    req_valid;
    logic [N*LW-1:0] req_len;
    logic [W-1:0]    op_a, op_b;
    logic            op_valid;
    logic            op_ready;
    logic [N-1:0]    grant;
    logic [W-1:0]    result;
    logic            result_ovf;
    logic            result_valid;

    escalonador_somador #(.WIDTH(W), .N_REQ(N), .LEN_W(LW)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_len      (req_len),
        .op_a         (op_a),
        .op_b         (op_b),
        .op_valid     (op_valid),
        .op_ready     (op_ready),
        .grant        (grant),
        .result       (result),
        .result_ovf   (result_ovf),
        .result_valid (result_valid)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;
    int m_last;
    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];
    int pat[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int arb(input logic [N-1:0] rv, input int last);
        for (int k = 1; k <= N; k++) begin
            if (rv[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [W-1:0] rnd_op();
        logic [63:0] t;
        case ($urandom_range(0, 2))
            0: t = 64'($urandom_range(0, 1000));
            1: t = {$urandom, $urandom};
            default: t = 64'(44'hFFF_FFFF_FFFF) - 64'($urandom_range(0, 50));
        endcase
        return t[W-1:0];
    endfunction

    // mode 0: op_valid always high, 1: random, 2: pattern from pat then high
    task automatic run_job(input logic [N-1:0] rv, input logic [N*LW-1:0] lens,
                           input int mode, input bit drop_req);
        int win, len, cyc, acc_cnt, stalls, pi;
        logic [N-1:0] exp_g;
        logic [W:0] t;
        logic [W-1:0] e_acc;
        bit e_ovf, done, g_bad, rdy_bad, v;

        win   = arb(rv, m_last);
        len   = int'(lens[win*LW +: LW]);
        exp_g = N'(1) << win;
        while (qa.size() < len) qa.push_back(rnd_op());
        while (qb.size() < len) qb.push_back(rnd_op());

        e_acc = '0;
        e_ovf = 1'b0;
        for (int i = 0; i < len; i++) begin
            t = {1'b0, qa[i]} + {1'b0, qb[i]};
            e_ovf |= t[W];
            t = {1'b0, e_acc} + {1'b0, t[W-1:0]};
            e_ovf |= t[W];
            e_acc = t[W-1:0];
        end

        req_valid = rv;
        req_len   = lens;
        cyc = 0;
        while (grant == '0 && cyc < 8) begin
            @(negedge clock);
            cyc++;
        end
        chk("grant_latency", 64'(cyc), 64'd1);
        chk("grant", 64'(grant), 64'(exp_g));
        if (drop_req) req_valid[win] = 1'b0;

        acc_cnt = 0; stalls = 0; pi = 0; cyc = 0;
        done = 0; g_bad = 0; rdy_bad = 0;
        while (!done && cyc < 200) begin
            if (result_valid) begin
                done = 1;
            end else begin
                case (mode)
                    0: v = 1'b1;
                    1: v = 1'($urandom_range(0, 1));
                    default: v = (pi < pat.size()) ? (pat[pi] != 0) : 1'b1;
                endcase
                op_valid = v;
                op_a = (acc_cnt < qa.size()) ? qa[acc_cnt] : rnd_op();
                op_b = (acc_cnt < qb.size()) ? qb[acc_cnt] : rnd_op();
                if (op_ready) begin
                    if (acc_cnt >= len) rdy_bad = 1;
                    if (v) acc_cnt++;
                    else stalls++;
                    pi++;
                end
                @(negedge clock);
                cyc++;
                if (grant !== exp_g) g_bad = 1;
            end
        end
        op_valid = 1'b0;
        chk("result_valid_seen", 64'(done), 64'd1);
        chk("latency", 64'(cyc), 64'(len + 2 + stalls));
        chk("accepts", 64'(acc_cnt), 64'(len));
        chk("ready_after_last", 64'(rdy_bad), 64'd0);
        chk("grant_hold", 64'(g_bad), 64'd0);
        chk("result", 64'(result), 64'(e_acc));
        chk("result_ovf", 64'(result_ovf), 64'(e_ovf));
        m_last = win;
        qa.delete();
        qb.delete();

        @(negedge clock);
        chk("pulse_one_cycle", 64'(result_valid), 64'd0);
        chk("result_holds", 64'(result), 64'(e_acc));
        chk("grant_idle", 64'(grant), 64'd0);
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        req_valid = '0;
        req_len   = '0;
        op_valid  = 1'b0;
        op_a      = '0;
        op_b      = '0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        m_last  = N - 1;
    endtask

    initial begin
        int cyc;
        bit seen;

        reset_n   = 1'b0;
        req_valid = '0;
        req_len   = '0;
        op_valid  = 1'b0;
        op_a      = '0;
        op_b      = '0;
        repeat (2) @(negedge clock);
        chk("rst_op_ready", 64'(op_ready), 64'd0);
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_ovf_valid", 64'({result_ovf, result_valid}), 64'd0);
        reset_n = 1'b1;
        m_last  = N - 1;

        // basic sum 2+2+4+4+5+5 = 22
        qa = '{44'd2, 44'd4, 44'd5};
        qb = '{44'd2, 44'd4, 44'd5};
        run_job(4'b0001, 16'h0003, 0, 0);

        // round robin 0,2,0 then wrap to 3
        do_reset();
        for (int j = 0; j < 3; j++) begin
            qa = '{44'd1};
            qb = '{44'd1};
            run_job(4'b0101, 16'h0101, 0, 0);
        end
        qa = '{44'd1};
        qb = '{44'd1};
        run_job(4'b1001, 16'h1001, 0, 0);

        // zero-length job on requester 2
        run_job(4'b0100, 16'h0000, 0, 0);

        // overflow, then a clean job clears the flag
        qa = '{44'hFFF_FFFF_FFFF, 44'd3};
        qb = '{44'd1, 44'd3};
        run_job(4'b0001, 16'h0002, 0, 0);
        qa = '{44'd1};
        qb = '{44'd1};
        run_job(4'b0001, 16'h0001, 0, 0);

        // toggled op_valid
        pat = '{1, 0, 0, 1, 0, 1};
        qa = '{44'd10, 44'd20, 44'd30};
        qb = '{44'd1, 44'd2, 44'd3};
        run_job(4'b0010, 16'h0030, 2, 0);

        // randomized jobs
        for (int j = 0; j < 40; j++) begin
            logic [N*LW-1:0] lens;
            for (int r = 0; r < N; r++) lens[r*LW +: LW] = LW'($urandom_range(0, 6));
            run_job(N'($urandom_range(1, 15)), lens, int'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));
        end

        // reset mid-ACCUM aborts the job
        req_valid = 4'b0100;
        req_len   = 16'h0500;
        op_valid  = 1'b1;
        op_a      = 44'd7;
        op_b      = 44'd9;
        cyc = 0;
        while (grant == '0 && cyc < 8) begin
            @(negedge clock);
            cyc++;
        end
        chk("abort_grant", 64'(grant), 64'h4);
        repeat (2) @(negedge clock);
        chk("abort_in_accum", 64'(op_ready), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_outputs", 64'({op_ready, grant, result_ovf, result_valid}), 64'd0);
        chk("abort_result", 64'(result), 64'd0);
        req_valid = '0;
        op_valid  = 1'b0;
        seen = 0;
        repeat (3) begin
            @(negedge clock);
            seen |= result_valid;
        end
        chk("abort_no_result", 64'(seen), 64'd0);
        reset_n = 1'b1;
        m_last  = N - 1;
        run_job(4'b1111, 16'h1111, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
